lsu: RTL and testbench

Load/store unit for the MEM stage of the pipelined MIPS core; the initiator side of the data-memory interface. It accepts one load or store from the pipeline and converts byte, halfword and word accesses into word-aligned memory requests with byte enables. It runs the request/grant/response handshake and returns sign- or zero-extended load data. The pipeline stalls MEM while an operation is outstanding.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu.sv | 186 ++++++++++++++++++
 tb/tb_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the MEM-stage load/store unit.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package lsu_pkg;

    // First illegal byte address (3072 words of data memory).
    localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_3000;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic is_store(input op_type_e t);
        return (t == OP_SW) || (t == OP_SH) || (t == OP_SB);
    endfunction

    // Only word and halfword loads are checked for alignment.
    function automatic logic is_misaligned(input op_type_e t, input logic [1:0] off);
        case (t)
            OP_LW:         return off != 2'b00;
            OP_LH, OP_LHU: return off[0];
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable / lane replication for stores, lane extract + extend for loads.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when outputs are used.
module lsu_align
    import lsu_pkg::*;
(
    input  op_type_e    st_type,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    input  op_type_e    ld_type,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] lane;

    // Store side: sub-word stores replicate data onto every lane, be selects the target.
    always_comb begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
        case (st_type)
            OP_SB: begin
                st_be        = 4'b0001 << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            OP_SH: begin
                st_be        = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
        endcase
    end

    // Load side: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        lane    = ld_rdata >> {ld_off, 3'b000};
        ld_data = lane;
        case (ld_type)
            OP_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  ld_data = {24'h0, lane[7:0]};
            OP_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  ld_data = {16'h0, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit, initiator of the req/gnt/rvalid data-memory port.
// Latency: fault 1 cycle, store 2 + grant wait, load 1 + grant wait + response wait + 1.
// Backpressure: mem_req and all mem_* held stable until mem_gnt; op_done pulses once per op.
// Optional trace of granted stores enabled by defining LSU_TRACE_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [31:0] op_pc,
    output logic        op_done,
    output logic [31:0] op_rdata,
    output logic        op_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    op_type_e    type_q, type_d;
    logic [1:0]  off_q, off_d;
    logic        op_done_q, op_done_d;
    logic        op_fault_q, op_fault_d;
    logic [31:0] op_rdata_q, op_rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    op_type_e    type_in;
    logic        fault_in;
    logic [3:0]  st_be;
    logic [31:0] st_wdata_rep;
    logic [31:0] ld_data;

    assign type_in  = op_type_e'(op_type);
    assign fault_in = is_misaligned(type_in, op_addr[1:0]) || (op_addr >= ADDR_LIMIT);

    // Store lanes come from the live op (registered at accept); loads use latched type/offset.
    lsu_align u_align (
        .st_type      (type_in),
        .st_off       (op_addr[1:0]),
        .st_wdata     (op_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata_rep),
        .ld_type      (type_q),
        .ld_off       (off_q),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    // Next-state and registered-output computation for the handshake FSM.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        off_d       = off_q;
        op_done_d   = 1'b0;
        op_fault_d  = 1'b0;
        op_rdata_d  = op_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && !op_done_q) begin
                    type_d     = type_in;
                    off_d      = op_addr[1:0];
                    op_rdata_d = 32'h0;
                    if (fault_in) begin
                        state_d    = ST_FIN;
                        op_done_d  = 1'b1;
                        op_fault_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(type_in);
                        mem_addr_d  = {op_addr[31:2], 2'b00};
                        mem_be_d    = st_be;
                        mem_wdata_d = st_wdata_rep;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d   = ST_FIN;
                        op_done_d = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    op_rdata_d = ld_data;
                    state_d    = ST_FIN;
                    op_done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            type_q      <= OP_LW;
            off_q       <= 2'b00;
            op_done_q   <= 1'b0;
            op_fault_q  <= 1'b0;
            op_rdata_q  <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            off_q       <= off_d;
            op_done_q   <= op_done_d;
            op_fault_q  <= op_fault_d;
            op_rdata_q  <= op_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign op_done   = op_done_q;
    assign op_fault  = op_fault_q;
    assign op_rdata  = op_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

`ifdef LSU_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] merged_word;

    assign merged_word = mem_wdata_q & {{8{mem_be_q[3]}}, {8{mem_be_q[2]}},
                                        {8{mem_be_q[1]}}, {8{mem_be_q[0]}}};

    // Trace-only PC capture at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= 32'h0;
        end else if (state_q == ST_IDLE && op_valid && !op_done_q) begin
            pc_q <= op_pc;
        end
    end

    // Print each store in the cycle it is granted.
    always @(posedge clk) begin
        if (reset && state_q == ST_REQ && mem_gnt && mem_we_q) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr_q, merged_word);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^op_pc;
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed scoreboard bench for the load/store unit.
// Latency: n/a (stimulus runs from a single initial block, outputs sampled 1ns after posedge).
// Backpressure: grant and response delays are varied per operation.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [31:0] op_pc;
    logic        op_done;
    logic [31:0] op_rdata;
    logic        op_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lsu dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_type    (op_type),
        .op_addr    (op_addr),
        .op_wdata   (op_wdata),
        .op_pc      (op_pc),
        .op_done    (op_done),
        .op_rdata   (op_rdata),
        .op_fault   (op_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation: push expectation, drive, respond with the given delays, check on op_done.
    // Called and returns at posedge+1ns; the caller's current cycle is cycle 0.
    task automatic do_op(input string name, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input int gnt_wait, input int rv_wait,
                         input logic [31:0] rd, input logic [31:0] exp_rdata,
                         input logic exp_fault, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata);
        exp_t e;
        exp_t got;
        int   req_cnt;
        int   done_cnt;
        int   gnt_cyc;
        int   last;
        e.rdata = exp_rdata;
        e.fault = exp_fault;
        e.addr  = {a[31:2], 2'b00};
        e.be    = exp_be;
        e.wdata = exp_wdata;
        e.we    = (t >= 3'd5);
        if (exp_fault)      e.done_cyc = 1;
        else if (e.we)      e.done_cyc = 2 + gnt_wait;
        else                e.done_cyc = 2 + gnt_wait + rv_wait;
        sb.push_back(e);
        req_cnt  = 0;
        done_cnt = 0;
        gnt_cyc  = 0;
        last     = e.done_cyc + 3;
        op_valid = 1'b1;
        op_type  = t;
        op_addr  = a;
        op_wdata = wd;
        op_pc    = 32'h0040_0000 + a;
        for (int c = 1; c <= last && c <= 40; c++) begin
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            if (mem_req) begin
                if (req_cnt == 0) chk({name, ".req_cycle"}, 32'(c), 32'd1);
                chk({name, ".addr"}, mem_addr, e.addr);
                chk({name, ".be"}, {28'h0, mem_be}, {28'h0, e.be});
                chk({name, ".we"}, {31'h0, mem_we}, {31'h0, e.we});
                if (e.we) chk({name, ".wdata"}, mem_wdata, e.wdata);
                if (req_cnt == gnt_wait) begin
                    mem_gnt = 1'b1;
                    gnt_cyc = c;
                end
                req_cnt++;
            end
            if (!e.we && gnt_cyc > 0 && c == gnt_cyc + rv_wait) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            if (op_done) begin
                done_cnt++;
                op_valid = 1'b0;
                if (done_cnt == 1 && sb.size() > 0) begin
                    got = sb.pop_front();
                    chk({name, ".done_cycle"}, 32'(c), 32'(got.done_cyc));
                    chk({name, ".rdata"}, op_rdata, got.rdata);
                    chk({name, ".fault"}, {31'h0, op_fault}, {31'h0, got.fault});
                end
            end
        end
        op_valid   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk({name, ".done_once"}, 32'(done_cnt), 32'd1);
        chk({name, ".req_cycles"}, 32'(req_cnt), exp_fault ? 32'd0 : 32'(gnt_wait + 1));
        while (sb.size() > 0) void'(sb.pop_front());
        step();
    endtask

    initial begin
        reset      = 1'b0;
        op_valid   = 1'b0;
        op_type    = 3'd0;
        op_addr    = 32'h0;
        op_wdata   = 32'h0;
        op_pc      = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Reset values.
        step();
        chk("rst.op_done", {31'h0, op_done}, 32'h0);
        chk("rst.op_fault", {31'h0, op_fault}, 32'h0);
        chk("rst.op_rdata", op_rdata, 32'h0);
        chk("rst.mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        step();

        // Stores.
        do_op("sw",  3'd5, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF);
        do_op("sb",  3'd7, 32'h13, 32'h0000_00A5, 0, 0, 32'h0, 32'h0, 1'b0, 4'b1000, 32'hA5A5_A5A5);
        do_op("sb1", 3'd7, 32'h11, 32'h1234_5677, 1, 0, 32'h0, 32'h0, 1'b0, 4'b0010, 32'h7777_7777);
        do_op("sh",  3'd6, 32'h12, 32'h1234_BEEF, 0, 0, 32'h0, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
        do_op("sh0", 3'd6, 32'h20, 32'h0000_C0DE, 2, 0, 32'h0, 32'h0, 1'b0, 4'b0011, 32'hC0DE_C0DE);

        // Loads with extraction/extension.
        do_op("lb",  3'd3, 32'h22, 32'h0, 0, 1, 32'h12F4_5678, 32'hFFFF_FFF4, 1'b0, 4'b1111, 32'h0);
        do_op("lbu", 3'd4, 32'h22, 32'h0, 0, 1, 32'h12F4_5678, 32'h0000_00F4, 1'b0, 4'b1111, 32'h0);
        do_op("lh",  3'd1, 32'h22, 32'h0, 0, 1, 32'h12F4_5678, 32'h0000_12F4, 1'b0, 4'b1111, 32'h0);
        do_op("lh0", 3'd1, 32'h20, 32'h0, 0, 2, 32'h1234_8765, 32'hFFFF_8765, 1'b0, 4'b1111, 32'h0);
        do_op("lhu", 3'd2, 32'h20, 32'h0, 1, 1, 32'h1234_8765, 32'h0000_8765, 1'b0, 4'b1111, 32'h0);
        do_op("lb1", 3'd3, 32'h21, 32'h0, 0, 1, 32'h0000_8000, 32'hFFFF_FF80, 1'b0, 4'b1111, 32'h0);
        do_op("lbu3",3'd4, 32'h23, 32'h0, 0, 1, 32'h9A00_0000, 32'h0000_009A, 1'b0, 4'b1111, 32'h0);
        do_op("lwlim",3'd0,32'h2FFC,32'h0, 0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0);

        // Faults: no request, done+fault in cycle 1.
        do_op("lwmis", 3'd0, 32'h06,   32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        do_op("lhmis", 3'd1, 32'h21,   32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        do_op("swlim", 3'd5, 32'h3000, 32'h1, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        do_op("lblim", 3'd3, 32'h3001, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);

        // Held-off grant and delayed response: request fields stable while waiting.
        do_op("lwwait", 3'd0, 32'h40, 32'h0, 3, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0);

        // Reset in RESP, then a stray rvalid.
        op_valid = 1'b1;
        op_type  = 3'd0;
        op_addr  = 32'h50;
        step();
        chk("rstresp.req", {31'h0, mem_req}, 32'h1);
        mem_gnt = 1'b1;
        step();
        mem_gnt  = 1'b0;
        op_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rstresp.mem_req", {31'h0, mem_req}, 32'h0);
        chk("rstresp.mem_addr", mem_addr, 32'h0);
        chk("rstresp.mem_be", {28'h0, mem_be}, 32'h0);
        chk("rstresp.op_done", {31'h0, op_done}, 32'h0);
        step();
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stray.op_done", {31'h0, op_done}, 32'h0);
            chk("stray.op_rdata", op_rdata, 32'h0);
            chk("stray.mem_req", {31'h0, mem_req}, 32'h0);
            step();
        end

        // Unit is back in IDLE and accepts normally.
        do_op("post", 3'd5, 32'h84, 32'h0102_0304, 0, 0, 32'h0, 32'h0, 1'b0, 4'b1111, 32'h0102_0304);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
